sram_responder: RTL

- Cycle-based, synthesizable model of the external SRAM device: the responder end of the processor's SRAM bus (sram_dq / sram_we_n / sram_address), whose initiator is the memory stage.
- Captures writes, returns read data after a programmable number of stable-address cycles, and tri-states the shared data bus whenever it is not returning read data.
- Used as the memory behind the core in system benches; also usable as the on-chip memory in FPGA builds.

---
 rtl/sram_responder.sv | 94 +++++++++
 1 files changed

// File: rtl/sram_responder.sv
// sram_responder: cycle-based responder for the external SRAM bus.
// Captures writes, returns read data once the address has been stable
// for READ_LATENCY edges, and floats the shared data bus otherwise.
module sram_responder #(
    parameter int ADDR_W       = 17,
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 1024,
    parameter int READ_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    inout  wire  [DATA_W-1:0] sram_dq,
    input  logic              sram_we_n,
    input  logic [ADDR_W-1:0] sram_address,
    output logic              rd_valid,
    output logic [15:0]       write_count
);

    localparam int         IDX_W = $clog2(DEPTH);
    localparam logic [3:0] RL4   = 4'(READ_LATENCY);

    typedef enum logic [1:0] {
        IDLE,
        READ_WAIT,
        READ_DRIVE,
        WRITE
    } state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state;
    logic [ADDR_W-1:0] last_addr;
    logic [3:0]        cnt;
    logic [DATA_W-1:0] rd_data;
    logic              oe;
    logic [IDX_W-1:0]  idx;
    logic              read_start;

    // Upper address bits are dropped, so addresses alias modulo DEPTH.
    assign idx = sram_address[IDX_W-1:0];

    // Any edge after a write, or any address change, restarts the latency count.
    assign read_start = (state == IDLE) || (state == WRITE) || (sram_address != last_addr);

    // The we_n gate is combinational so the bus releases as soon as the initiator starts a write.
    assign rd_valid = oe & sram_we_n;
    assign sram_dq  = rd_valid ? rd_data : 'z;

    // Storage capture: memory is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (!sram_we_n) begin
            mem[idx] <= sram_dq;
        end
    end

    // Responder FSM: write capture, latency counting and read-data drive.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            last_addr   <= '0;
            cnt         <= '0;
            rd_data     <= '0;
            oe          <= 1'b0;
            write_count <= '0;
        end else if (!sram_we_n) begin
            state     <= WRITE;
            oe        <= 1'b0;
            last_addr <= sram_address;
            if (write_count != 16'hFFFF) begin
                write_count <= write_count + 16'd1;
            end
        end else if (read_start) begin
            last_addr <= sram_address;
            cnt       <= 4'd1;
            if (READ_LATENCY == 1) begin
                rd_data <= mem[idx];
                oe      <= 1'b1;
                state   <= READ_DRIVE;
            end else begin
                oe    <= 1'b0;
                state <= READ_WAIT;
            end
        end else if (state == READ_WAIT) begin
            cnt <= cnt + 4'd1;
            if (cnt + 4'd1 == RL4) begin
                rd_data <= mem[idx];
                oe      <= 1'b1;
                state   <= READ_DRIVE;
            end
        end
        // READ_DRIVE at the same address holds oe and rd_data.
    end

endmodule
